vga_monitor: RTL and testbench

VGA_MONITOR -- requirements
Module: vga_monitor

---
 rtl/vga_monitor.sv | 253 +++++++++++++++++++++++++
 tb/tb_vga_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_monitor.sv
// vga_monitor: passive timing monitor for a TinyVGA pin byte. Recovers
// horizontal/vertical alignment from the sync edges and reports visible
// pixels with their coordinates. It also keeps a per-frame checksum and
// tracks sync and blanking violations.
module vga_monitor #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33,
  parameter int SYNC_LAG  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [5:0]  rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [15:0] frame_count,
  output logic        sync_err,
  output logic [7:0]  err_count,
  output logic        blank_err
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  // Sync edges arrive SYNC_LAG samples after the pixel data they belong to,
  // so the expected hsync column already includes that lag.
  localparam logic [9:0] HS_COL     = 10'(H_DISPLAY + H_FRONT + SYNC_LAG);
  localparam logic [9:0] HS_REALIGN = 10'(H_DISPLAY + H_FRONT + SYNC_LAG + 1);
  localparam logic [9:0] VS_LINE    = 10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP_W   = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP_W   = 10'(V_DISPLAY);
  localparam logic [9:0] X_LAST     = 10'(H_DISPLAY - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_DISPLAY - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    HSEEN  = 2'd1,
    VWAIT  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // Rotate-left-by-one used by the frame checksum.
  function automatic logic [15:0] rol1(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

  state_t      state_r, state_next_s;
  logic        hsync_prev_r, vsync_prev_r;
  logic [9:0]  hcnt_r, vcnt_r;
  logic [15:0] acc_r;

  logic        locked_r, pix_valid_r, frame_done_r, sync_err_r, blank_err_r;
  logic [9:0]  x_r, y_r;
  logic [5:0]  rgb_r;
  logic [15:0] frame_sum_r, frame_count_r;
  logic [7:0]  err_count_r;

  logic        hsync_s, vsync_s, hsync_rise_s, vsync_rise_s;
  logic        h_bad_s, v_bad_s;
  logic [5:0]  rgb_s;
  logic        in_display_s, visible_s, first_pix_s, last_pix_s;
  logic [15:0] acc_next_s;
  logic        h_realign_s, v_set_s, sync_err_s;

  // Pin decode and sync edge detection against the previous sample.
  always_comb begin
    hsync_s      = vga_in[7];
    vsync_s      = vga_in[3];
    rgb_s        = {vga_in[0], vga_in[4], vga_in[1], vga_in[5], vga_in[2], vga_in[6]};
    hsync_rise_s = hsync_s & ~hsync_prev_r;
    vsync_rise_s = vsync_s & ~vsync_prev_r;
    h_bad_s      = hsync_rise_s & (hcnt_r != HS_COL);
    v_bad_s      = vsync_rise_s & (vcnt_r != VS_LINE);
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Lock acquisition / loss transitions.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      HUNT: begin
        if (hsync_rise_s) state_next_s = HSEEN;
        else              state_next_s = HUNT;
      end
      HSEEN: begin
        if (hsync_rise_s && !h_bad_s) state_next_s = VWAIT;
        else                          state_next_s = HSEEN;
      end
      VWAIT: begin
        if (h_bad_s)           state_next_s = HUNT;
        else if (vsync_rise_s) state_next_s = LOCKED;
        else                   state_next_s = VWAIT;
      end
      LOCKED: begin
        if (h_bad_s || v_bad_s) state_next_s = HUNT;
        else                    state_next_s = LOCKED;
      end
      default: state_next_s = HUNT;
    endcase
  end

  // Per-state counter alignment commands and sync error detection.
  always_comb begin
    h_realign_s = 1'b0;
    v_set_s     = 1'b0;
    sync_err_s  = 1'b0;
    case (state_r)
      HUNT: begin
        if (hsync_rise_s) h_realign_s = 1'b1;
        else              h_realign_s = 1'b0;
      end
      HSEEN: begin
        if (h_bad_s) h_realign_s = 1'b1;
        else         h_realign_s = 1'b0;
      end
      VWAIT: begin
        if (vsync_rise_s && !h_bad_s) v_set_s = 1'b1;
        else                          v_set_s = 1'b0;
      end
      LOCKED: begin
        if (h_bad_s || v_bad_s) sync_err_s = 1'b1;
        else                    sync_err_s = 1'b0;
      end
      default: begin
        h_realign_s = 1'b0;
        v_set_s     = 1'b0;
        sync_err_s  = 1'b0;
      end
    endcase
  end

  // Pixel classification and next checksum value.
  always_comb begin
    in_display_s = (hcnt_r < H_DISP_W) && (vcnt_r < V_DISP_W);
    visible_s    = (state_r == LOCKED) && in_display_s;
    first_pix_s  = (hcnt_r == 10'd0) && (vcnt_r == 10'd0);
    last_pix_s   = (hcnt_r == X_LAST) && (vcnt_r == Y_LAST);
    if (first_pix_s) acc_next_s = {10'b0, rgb_s};
    else             acc_next_s = rol1(acc_r) ^ {10'b0, rgb_s};
  end

  // Sync edge history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_prev_r <= 1'b0;
      vsync_prev_r <= 1'b0;
    end else begin
      hsync_prev_r <= hsync_s;
      vsync_prev_r <= vsync_s;
    end
  end

  // Column/line counters, realigned on sync edges while acquiring lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_r <= 10'd0;
      vcnt_r <= 10'd0;
    end else begin
      if (h_realign_s)           hcnt_r <= HS_REALIGN;
      else if (hcnt_r == H_LAST) hcnt_r <= 10'd0;
      else                       hcnt_r <= hcnt_r + 10'd1;

      if (v_set_s)                                vcnt_r <= VS_LINE;
      else if (hcnt_r == H_LAST && !h_realign_s) begin
        if (vcnt_r == V_LAST) vcnt_r <= 10'd0;
        else                  vcnt_r <= vcnt_r + 10'd1;
      end
    end
  end

  // Registered lock flag and visible-pixel outputs (x/y/rgb hold in blanking).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked_r    <= 1'b0;
      pix_valid_r <= 1'b0;
      x_r         <= 10'd0;
      y_r         <= 10'd0;
      rgb_r       <= 6'd0;
    end else begin
      locked_r    <= (state_next_s == LOCKED);
      pix_valid_r <= visible_s;
      if (visible_s) begin
        x_r   <= hcnt_r;
        y_r   <= vcnt_r;
        rgb_r <= rgb_s;
      end
    end
  end

  // Frame checksum; a frame only completes if lock held from (0,0) onwards,
  // since relocking always happens in vertical blanking before (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r         <= 16'd0;
      frame_done_r  <= 1'b0;
      frame_sum_r   <= 16'd0;
      frame_count_r <= 16'd0;
    end else begin
      frame_done_r <= visible_s && last_pix_s;
      if (visible_s) acc_r <= acc_next_s;
      if (visible_s && last_pix_s) begin
        frame_sum_r   <= acc_next_s;
        frame_count_r <= frame_count_r + 16'd1;
      end
    end
  end

  // Sync error pulse, saturating error count and sticky blanking error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_err_r  <= 1'b0;
      err_count_r <= 8'd0;
      blank_err_r <= 1'b0;
    end else begin
      sync_err_r <= sync_err_s;
      if (sync_err_s && err_count_r != 8'hFF) err_count_r <= err_count_r + 8'd1;
      if (state_r == LOCKED && !in_display_s && rgb_s != 6'd0) blank_err_r <= 1'b1;
    end
  end

  assign locked      = locked_r;
  assign pix_valid   = pix_valid_r;
  assign x           = x_r;
  assign y           = y_r;
  assign rgb         = rgb_r;
  assign frame_done  = frame_done_r;
  assign frame_sum   = frame_sum_r;
  assign frame_count = frame_count_r;
  assign sync_err    = sync_err_r;
  assign err_count   = err_count_r;
  assign blank_err   = blank_err_r;

endmodule

// File: tb/tb_vga_monitor.sv
// tb_vga_monitor: drives a scaled-down VGA timing (24x15 total, 16x8 visible)
// from a frame buffer and checks the monitor against the frame contents.
module tb_vga_monitor;

  localparam int HD = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VD = 8,  VB = 2, VSW = 2, VTP = 3;
  localparam int HT = HD + HF + HSW + HB;
  localparam int VT = VD + VB + VSW + VTP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  vga_in;
  logic        locked, pix_valid, frame_done, sync_err, blank_err;
  logic [9:0]  x, y;
  logic [5:0]  rgb;
  logic [15:0] frame_sum, frame_count;
  logic [7:0]  err_count;

  vga_monitor #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VSW), .V_TOP(VTP),
    .SYNC_LAG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
    .locked(locked), .pix_valid(pix_valid), .x(x), .y(y), .rgb(rgb),
    .frame_done(frame_done), .frame_sum(frame_sum), .frame_count(frame_count),
    .sync_err(sync_err), .err_count(err_count), .blank_err(blank_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Source picture and generator state (data position of the next sample).
  logic [5:0] fb [VD][HD];
  int   gx, gy;
  logic ph, pv;
  int   hdel_line = -1;
  int   vshift    = 0;
  int   inj_col   = -1;
  int   inj_line  = -1;
  logic [5:0] inj_rgb = 6'd0;

  // Expectations maintained from scenario knowledge.
  logic mon_en    = 1'b0;
  logic mon_lock  = 1'b0;
  logic exp_blank = 1'b0;
  int   exp_fc    = 0;
  int   fc_save;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Checksum of the whole frame buffer in raster order.
  function automatic logic [15:0] model_sum();
    logic [15:0] acc;
    acc = 16'h0000;
    for (int yy = 0; yy < VD; yy++)
      for (int xx = 0; xx < HD; xx++)
        acc = {acc[14:0], acc[15]} ^ {10'h000, fb[yy][xx]};
    return acc;
  endfunction

  task automatic fb_clear();
    for (int yy = 0; yy < VD; yy++)
      for (int xx = 0; xx < HD; xx++)
        fb[yy][xx] = 6'd0;
  endtask

  task automatic fb_random();
    for (int yy = 0; yy < VD; yy++)
      for (int xx = 0; xx < HD; xx++)
        fb[yy][xx] = 6'($urandom_range(0, 63));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".locked"},      {31'd0, locked},      32'd0);
    chk({tag, ".pix_valid"},   {31'd0, pix_valid},   32'd0);
    chk({tag, ".x"},           {22'd0, x},           32'd0);
    chk({tag, ".y"},           {22'd0, y},           32'd0);
    chk({tag, ".rgb"},         {26'd0, rgb},         32'd0);
    chk({tag, ".frame_done"},  {31'd0, frame_done},  32'd0);
    chk({tag, ".frame_sum"},   {16'd0, frame_sum},   32'd0);
    chk({tag, ".frame_count"}, {16'd0, frame_count}, 32'd0);
    chk({tag, ".sync_err"},    {31'd0, sync_err},    32'd0);
    chk({tag, ".err_count"},   {24'd0, err_count},   32'd0);
    chk({tag, ".blank_err"},   {31'd0, blank_err},   32'd0);
  endtask

  // One pixel clock: drive the sample, let the DUT take it, check the result.
  task automatic tick();
    logic       vis, ph_n, pv_n, exp_pv;
    logic [5:0] d;
    int         hs_lo, vs_lo;
    vis = (gx < HD) && (gy < VD);
    d = 6'd0;
    if (vis) d = fb[gy][gx];
    if (gx == inj_col && gy == inj_line) d = inj_rgb;
    vga_in = {ph, d[0], d[2], d[4], pv, d[1], d[3], d[5]};
    hs_lo = HD + HF + ((gy == hdel_line) ? 3 : 0);
    vs_lo = VD + VB + vshift;
    ph_n  = (gx >= hs_lo) && (gx < hs_lo + HSW);
    pv_n  = (gy >= vs_lo) && (gy < vs_lo + VSW);
    if (mon_lock && !vis && d != 6'd0) exp_blank = 1'b1;
    @(posedge clk);
    #1;
    ph = ph_n;
    pv = pv_n;
    if (mon_en) begin
      exp_pv = mon_lock && vis;
      chk("pix_valid", {31'd0, pix_valid}, {31'd0, exp_pv});
      if (exp_pv) begin
        chk("x",   {22'd0, x},   gx);
        chk("y",   {22'd0, y},   gy);
        chk("rgb", {26'd0, rgb}, {26'd0, d});
      end
      if (exp_pv && gx == HD - 1 && gy == VD - 1) begin
        exp_fc++;
        chk("frame_done",  {31'd0, frame_done},  32'd1);
        chk("frame_sum",   {16'd0, frame_sum},   {16'd0, model_sum()});
        chk("frame_count", {16'd0, frame_count}, exp_fc & 32'hFFFF);
      end else begin
        chk("frame_done_idle", {31'd0, frame_done}, 32'd0);
      end
      chk("blank_err", {31'd0, blank_err}, {31'd0, exp_blank});
    end
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy++;
      if (gy == VT) gy = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    vga_in = 8'd0;
    gx = 0; gy = 0; ph = 1'b0; pv = 1'b0;
    fb_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("por");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Acquisition frame: lock appears right after the first vsync rise.
    run(HT * (VD + VB));
    chk("locked_before_vs", {31'd0, locked}, 32'd0);
    run(2);
    chk("locked_after_vs", {31'd0, locked}, 32'd1);
    run(FRAME - HT * (VD + VB) - 2);

    // Two clean black frames.
    mon_lock = 1'b1;
    run(FRAME);
    chk("x_hold", {22'd0, x}, HD - 1);
    chk("y_hold", {22'd0, y}, VD - 1);
    chk("black_sum", {16'd0, frame_sum}, 32'h0000);
    run(FRAME);
    chk("black_count", {16'd0, frame_count}, 32'd2);
    chk("black_errs",  {24'd0, err_count},   32'd0);

    // Random content.
    repeat (2) begin
      fb_random();
      run(FRAME);
    end

    // Single-pixel checksums.
    fb_clear(); fb[VD-1][HD-1] = 6'd1;
    run(FRAME);
    chk("sum_last_px", {16'd0, frame_sum}, 32'h0001);
    fb_clear(); fb[VD-1][HD-2] = 6'd1;
    run(FRAME);
    chk("sum_prev_px", {16'd0, frame_sum}, 32'h0002);
    fb_clear(); fb[0][0] = 6'd63;
    run(FRAME);
    // 63 rotated left 127 times in 16 bits is a single rotate right.
    chk("sum_first_px", {16'd0, frame_sum}, 32'h801F);

    // One hsync pulse delayed by 3 samples on line 3.
    fb_random();
    hdel_line = 3;
    run(HT * 3 + 22);
    chk("hdel_pre_err", {31'd0, sync_err}, 32'd0);
    run(1);
    chk("hdel_err",    {31'd0, sync_err}, 32'd1);
    chk("hdel_errcnt", {24'd0, err_count}, 32'd1);
    chk("hdel_unlock", {31'd0, locked},   32'd0);
    mon_lock = 1'b0;
    run(1);
    chk("hdel_err_pulse", {31'd0, sync_err}, 32'd0);
    run(FRAME - (HT * 3 + 24));
    hdel_line = -1;
    chk("hdel_relock", {31'd0, locked}, 32'd1);
    mon_lock = 1'b1;
    run(FRAME);

    // Vsync arriving one line late.
    vshift = 1;
    run(HT * (VD + VB + 1) + 1);
    chk("vs_pre_err", {31'd0, sync_err}, 32'd0);
    run(1);
    chk("vs_err",    {31'd0, sync_err},  32'd1);
    chk("vs_errcnt", {24'd0, err_count}, 32'd2);
    chk("vs_unlock", {31'd0, locked},    32'd0);
    mon_lock = 1'b0;
    run(FRAME - HT * (VD + VB + 1) - 2);
    vshift = 0;
    fc_save = exp_fc;
    run(FRAME);
    chk("vs_count_kept", {16'd0, frame_count}, fc_save);
    chk("vs_relock",     {31'd0, locked},      32'd1);
    mon_lock = 1'b1;
    run(FRAME);

    // Non-black data in horizontal blanking.
    fb_random();
    inj_col = 20; inj_line = 2; inj_rgb = 6'b110000;
    run(FRAME);
    inj_col = -1; inj_line = -1;
    chk("blank_set", {31'd0, blank_err}, 32'd1);
    run(FRAME);
    chk("blank_sticky", {31'd0, blank_err}, 32'd1);

    // Reset pulse in the middle of the visible area.
    run(HT * 4 + 8);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    run(1);
    chk_reset_state("mid_rst");
    rst_n     = 1'b1;
    exp_blank = 1'b0;
    exp_fc    = 0;
    mon_lock  = 1'b0;
    mon_en    = 1'b1;
    run(FRAME - (HT * 4 + 9));
    chk("rst_relock", {31'd0, locked}, 32'd1);
    mon_lock = 1'b1;
    run(FRAME);
    chk("rst_count", {16'd0, frame_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
